i2s_transmit: RTL and testbench

I2S transmitter, the sending counterpart of the I2S receiver. It runs as the I2S timing master on the bit clock `sck` and generates `ws` and `sd`. Stereo sample pairs arrive on a valid/ready interface and are serialised MSB-first, with `sd` lagging `ws` by one bit clock. A one-pair holding buffer decouples the upstream source from frame timing, and underruns are flagged.

---
 rtl/i2s_transmit_if.sv | 11 +
 rtl/i2s_transmit.sv | 89 ++++++++
 tb/tb_i2s_transmit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmit_if.sv
// i2s_transmit_if: valid/ready stereo-pair stream feeding the I2S transmitter.
interface i2s_transmit_if #(
    parameter int word_size = 32
);
    logic [word_size-1:0] in_left;
    logic [word_size-1:0] in_right;
    logic                 in_valid;
    logic                 in_ready;
    modport master (output in_left, output in_right, output in_valid, input in_ready);
    modport slave (input in_left, input in_right, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_transmit.sv
// i2s_transmit: I2S timing master on falling sck edges, stereo pairs serialised MSB-first one sck after ws.
// Define I2S_TX_REPEAT_LAST_EN to replay the last transmitted pair on underrun instead of zeros.
module i2s_transmit #(
    parameter int word_size = 32,
    parameter int slot_bits = 32
) (
    input  logic          sck,
    input  logic          rst,
    i2s_transmit_if.slave s,
    output logic          ws,
    output logic          sd,
    output logic          underrun
);
    localparam int cw = $clog2(slot_bits);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;
    logic [cw-1:0] bit_cnt;
    logic [slot_bits-1:0] sh_l, sh_r;
    logic [word_size-1:0] buf_l, buf_r, ld_l, ld_r;
    logic full, accept, wrap, frame_start;
`ifdef I2S_TX_REPEAT_LAST_EN
    logic [word_size-1:0] last_l, last_r;
`endif

    // Left-align the sample in the slot: truncates low bits or pads zeros after the LSB.
    function automatic logic [slot_bits-1:0] fit(input logic [word_size-1:0] w);
        logic [word_size+slot_bits-1:0] t;
        t = {w, {slot_bits{1'b0}}};
        return t[word_size+slot_bits-1 -: slot_bits];
    endfunction

    assign s.in_ready = !full && rst;

    always_comb begin
        accept = s.in_valid && s.in_ready;
        wrap = state == IDLE || bit_cnt == cw'(slot_bits - 1);
        frame_start = wrap && ws;
        state_nx = RUN;
`ifdef I2S_TX_REPEAT_LAST_EN
        ld_l = full ? buf_l : last_l;
        ld_r = full ? buf_r : last_r;
`else
        ld_l = full ? buf_l : '0;
        ld_r = full ? buf_r : '0;
`endif
    end

    // sd takes the MSB of the channel whose slot ws currently shows, giving the one-cycle lag.
    always_ff @(negedge sck) begin
        if (!rst) begin
            state    <= IDLE;
            ws       <= 1'b1;
            sd       <= 1'b0;
            underrun <= 1'b0;
            full     <= 1'b0;
            bit_cnt  <= '0;
            sh_l     <= '0;
            sh_r     <= '0;
        end else begin
            state    <= state_nx;
            ws       <= wrap ? !ws : ws;
            bit_cnt  <= wrap ? '0 : bit_cnt + 1'b1;
            sd       <= ws ? sh_r[slot_bits-1] : sh_l[slot_bits-1];
            underrun <= frame_start && !full;
            full     <= accept || (full && !frame_start);
            sh_l     <= frame_start ? fit(ld_l) : ws ? sh_l : sh_l << 1;
            sh_r     <= frame_start ? fit(ld_r) : ws ? sh_r << 1 : sh_r;
        end
    end

    always_ff @(negedge sck) begin
        if (accept) begin
            buf_l <= s.in_left;
            buf_r <= s.in_right;
        end
    end

`ifdef I2S_TX_REPEAT_LAST_EN
    always_ff @(negedge sck) begin
        if (!rst) begin
            last_l <= '0;
            last_r <= '0;
        end else if (frame_start && full) begin
            last_l <= buf_l;
            last_r <= buf_r;
        end
    end
`endif
endmodule

// File: tb/tb_i2s_transmit.sv
// tb_i2s_transmit: three transmitters (slot 32/24/40) against a frame-position reference model plus loopback receivers.
module tb_i2s_transmit;
    logic sck = 1'b0;
    logic rst = 1'b0;
    always #5 sck = ~sck;

    int sba [3] = '{32, 24, 40};
    logic vld [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] dl [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] dr [3] = '{32'h0, 32'h0, 32'h0};
    logic ws_o [3], sd_o [3], und_o [3], rdy [3];

    i2s_transmit_if #(.word_size(32)) if0 ();
    i2s_transmit_if #(.word_size(32)) if1 ();
    i2s_transmit_if #(.word_size(32)) if2 ();
    assign if0.in_valid = vld[0];
    assign if0.in_left  = dl[0];
    assign if0.in_right = dr[0];
    assign rdy[0]       = if0.in_ready;
    assign if1.in_valid = vld[1];
    assign if1.in_left  = dl[1];
    assign if1.in_right = dr[1];
    assign rdy[1]       = if1.in_ready;
    assign if2.in_valid = vld[2];
    assign if2.in_left  = dl[2];
    assign if2.in_right = dr[2];
    assign rdy[2]       = if2.in_ready;

    i2s_transmit #(.word_size(32), .slot_bits(32)) u0 (.sck(sck), .rst(rst), .s(if0), .ws(ws_o[0]), .sd(sd_o[0]), .underrun(und_o[0]));
    i2s_transmit #(.word_size(32), .slot_bits(24)) u1 (.sck(sck), .rst(rst), .s(if1), .ws(ws_o[1]), .sd(sd_o[1]), .underrun(und_o[1]));
    i2s_transmit #(.word_size(32), .slot_bits(40)) u2 (.sck(sck), .rst(rst), .s(if2), .ws(ws_o[2]), .sd(sd_o[2]), .underrun(und_o[2]));

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Loopback receivers sample mid-cycle; a slot closes on the sample where ws changes.
    logic [63:0] racc [3] = '{64'h0, 64'h0, 64'h0};
    int rnb [3] = '{0, 0, 0};
    logic pws [3] = '{1'b1, 1'b1, 1'b1};
    logic [63:0] rx_l [3], rx_r [3];
    int rx_ln [3], rx_rn [3];
    int rx_frames [3] = '{0, 0, 0};

    always @(posedge sck) begin
        for (int d = 0; d < 3; d++) begin
            logic [63:0] a;
            a = {racc[d][62:0], sd_o[d]};
            if (ws_o[d] !== pws[d]) begin
                if (pws[d] === 1'b1) begin
                    rx_r[d] = a;
                    rx_rn[d] = rnb[d] + 1;
                    rx_frames[d]++;
                end else begin
                    rx_l[d] = a;
                    rx_ln[d] = rnb[d] + 1;
                end
                racc[d] = '0;
                rnb[d] = 0;
            end else begin
                racc[d] = a;
                rnb[d]++;
            end
            pws[d] = ws_o[d];
        end
    end

    // Reference model: position within the frame since the last frame start decides every output.
    bit m_run [3] = '{1'b0, 1'b0, 1'b0};
    int m_t [3] = '{0, 0, 0};
    bit m_full [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] m_bl [3], m_br [3];
    logic [31:0] m_cl [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] m_cr [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] m_ll [3] = '{32'h0, 32'h0, 32'h0};
    logic [31:0] m_lr [3] = '{32'h0, 32'h0, 32'h0};
    logic e_ws [3], e_sd [3], e_und [3];

    function automatic logic bitof(input logic [31:0] w, input int i);
        return (i >= 0 && i < 32) ? w[31-i] : 1'b0;
    endfunction

    task automatic model_edge(input int d, input bit acc);
        int sb, p;
        bit fs;
        sb = sba[d];
        if (!rst) begin
            m_run[d] = 0; m_t[d] = 0; m_full[d] = 0;
            m_cl[d] = '0; m_cr[d] = '0; m_ll[d] = '0; m_lr[d] = '0;
            e_ws[d] = 1'b1; e_sd[d] = 1'b0; e_und[d] = 1'b0;
        end else begin
            m_t[d] = m_run[d] ? m_t[d] + 1 : 0;
            p = m_t[d] % (2 * sb);
            fs = (p == 0);
            e_ws[d] = (p >= sb);
            e_sd[d] = fs ? bitof(m_cr[d], sb - 1) : (p <= sb) ? bitof(m_cl[d], p - 1) : bitof(m_cr[d], p - sb - 1);
            e_und[d] = fs && !m_full[d];
            if (fs && m_full[d]) begin
                m_cl[d] = m_bl[d]; m_cr[d] = m_br[d];
                m_ll[d] = m_bl[d]; m_lr[d] = m_br[d];
                m_full[d] = 0;
            end else if (fs) begin
`ifdef I2S_TX_REPEAT_LAST_EN
                m_cl[d] = m_ll[d]; m_cr[d] = m_lr[d];
`else
                m_cl[d] = '0; m_cr[d] = '0;
`endif
            end
            if (acc) begin
                m_bl[d] = dl[d]; m_br[d] = dr[d]; m_full[d] = 1;
            end
            m_run[d] = 1;
        end
    endtask

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, d, cyc, act, exp);
        end
    endtask

    task automatic cycle();
        bit acc [3];
        for (int d = 0; d < 3; d++) acc[d] = vld[d] && !m_full[d] && rst;
        @(negedge sck);
        for (int d = 0; d < 3; d++) model_edge(d, acc[d]);
        #1;
        cyc++;
        for (int d = 0; d < 3; d++) begin
            chk("ws", d, 64'(ws_o[d]), 64'(e_ws[d]));
            chk("sd", d, 64'(sd_o[d]), 64'(e_sd[d]));
            chk("underrun", d, 64'(und_o[d]), 64'(e_und[d]));
            chk("in_ready", d, 64'(rdy[d]), 64'(!m_full[d] && rst));
        end
    endtask

    function automatic bit next_fs(input int d);
        return !m_run[d] || ((m_t[d] + 1) % (2 * sba[d]) == 0);
    endfunction

    task automatic send(input int d, input logic [31:0] l, input logic [31:0] r);
        int n = 0;
        while ((rdy[d] !== 1'b1 || next_fs(d)) && n < 400) begin
            cycle();
            n++;
        end
        chk("send_timeout", d, 64'(n < 400), 64'd1);
        dl[d] = l;
        dr[d] = r;
        vld[d] = 1'b1;
        cycle();
        vld[d] = 1'b0;
    endtask

    task automatic wait_frames(input int d, input int target);
        int n = 0;
        while (rx_frames[d] < target && n < 400) begin
            cycle();
            n++;
        end
        chk("frame_timeout", d, 64'(rx_frames[d] >= target), 64'd1);
    endtask

    task automatic wait_pos(input int d, input int p);
        int n = 0;
        while (m_t[d] % (2 * sba[d]) != p && n < 400) begin
            cycle();
            n++;
        end
        chk("pos_timeout", d, 64'(n < 400), 64'd1);
    endtask

    typedef struct {
        int d;
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] xl;
        logic [63:0] xr;
        int xn;
    } vec_t;

    initial begin
        vec_t vt [4];
        int fc, n;
        logic [63:0] xl, xr;
        vt[0] = '{0, 32'hA5A5_0F0F, 32'h1234_5678, 64'hA5A5_0F0F, 64'h1234_5678, 32};
        vt[1] = '{1, 32'hDEAD_BEEF, 32'h0000_0000, 64'hDE_ADBE, 64'h0, 24};
        vt[2] = '{2, 32'h0000_0001, 32'hFFFF_FFFF, 64'h00_0000_0100, 64'hFF_FFFF_FF00, 40};
        vt[3] = '{1, 32'h1357_9BDF, 32'hFEDC_BA98, 64'h13_579B, 64'hFE_DCBA, 24};

        repeat (4) cycle();
        chk("rst_ws", 0, 64'(ws_o[0]), 64'd1);
        chk("rst_sd", 0, 64'(sd_o[0]), 64'd0);
        chk("rst_ready", 0, 64'(rdy[0]), 64'd0);
        rst = 1'b1;
        cycle();
        for (int d = 0; d < 3; d++) begin
            chk("first_underrun", d, 64'(und_o[d]), 64'd1);
            chk("first_ws", d, 64'(ws_o[d]), 64'd0);
        end

        for (int i = 0; i < 4; i++) begin
            send(vt[i].d, vt[i].l, vt[i].r);
            fc = rx_frames[vt[i].d];
            wait_frames(vt[i].d, fc + 2);
            chk("slot_l", vt[i].d, rx_l[vt[i].d], vt[i].xl);
            chk("slot_r", vt[i].d, rx_r[vt[i].d], vt[i].xr);
            chk("len_l", vt[i].d, 64'(rx_ln[vt[i].d]), 64'(vt[i].xn));
            chk("len_r", vt[i].d, 64'(rx_rn[vt[i].d]), 64'(vt[i].xn));
        end

        // Backpressure: second pair stalls until the first is drained, then frames play in order.
        send(0, 32'h0F1E_2D3C, 32'h4B5A_6978);
        chk("bp_ready_low", 0, 64'(rdy[0]), 64'd0);
        send(0, 32'h8796_A5B4, 32'hC3D2_E1F0);
        fc = rx_frames[0];
        wait_frames(0, fc + 1);
        chk("bp_first_l", 0, rx_l[0], 64'h0F1E_2D3C);
        chk("bp_first_r", 0, rx_r[0], 64'h4B5A_6978);
        wait_frames(0, fc + 2);
        chk("bp_second_l", 0, rx_l[0], 64'h8796_A5B4);
        chk("bp_second_r", 0, rx_r[0], 64'hC3D2_E1F0);

        send(0, 32'h8000_0001, 32'h7FFF_FFFE);
        fc = rx_frames[0];
        wait_frames(0, fc + 2);
        chk("ur_pair_l", 0, rx_l[0], 64'h8000_0001);
        chk("ur_pair_r", 0, rx_r[0], 64'h7FFF_FFFE);
        n = 0;
        repeat (64) begin
            cycle();
            n += int'(und_o[0]);
        end
        chk("ur_pulses", 0, 64'(n), 64'd1);
        wait_frames(0, fc + 3);
`ifdef I2S_TX_REPEAT_LAST_EN
        xl = 64'h8000_0001; xr = 64'h7FFF_FFFE;
`else
        xl = 64'h0; xr = 64'h0;
`endif
        chk("ur_frame_l", 0, rx_l[0], xl);
        chk("ur_frame_r", 0, rx_r[0], xr);

        // Reset lands on the edge that would drive left bit 10, with a pair sitting in the buffer.
        wait_pos(0, 8);
        dl[0] = 32'hCAFE_F00D;
        dr[0] = 32'hCAFE_F00D;
        vld[0] = 1'b1;
        cycle();
        vld[0] = 1'b0;
        chk("mr_ready_low", 0, 64'(rdy[0]), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();
        chk("mr_ws", 0, 64'(ws_o[0]), 64'd1);
        chk("mr_sd", 0, 64'(sd_o[0]), 64'd0);
        chk("mr_ready", 0, 64'(rdy[0]), 64'd0);
        rst = 1'b1;
        cycle();
        chk("mr_underrun", 0, 64'(und_o[0]), 64'd1);
        fc = rx_frames[0];
        wait_frames(0, fc + 2);
        chk("mr_dropped_l", 0, rx_l[0], 64'h0);
        chk("mr_dropped_r", 0, rx_r[0], 64'h0);

        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 3; d++) begin
                vld[d] = ($urandom_range(0, 3) == 0);
                dl[d] = $urandom;
                dr[d] = $urandom;
            end
            rst = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst = 1'b1;
        for (int d = 0; d < 3; d++) vld[d] = 1'b0;
        repeat (100) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end
endmodule
